// File: rtl/miinst_dispatch_queue_if.sv
// Micro-instruction type package plus the dispatch-queue handshake interface.
// Ports (interface signals): enq_miinst/enq_valid/enq_ready (upstream enqueue), stall/flush (decode control),
//   deq_miinst_head/deq_valid (head entry to decode), count (occupancy). master = upstream/decode side, slave = queue.
package miinst_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } miinst_t;

  // A nop keeps the pc of the last consumed instruction so decode still sees a sane pc.
  function automatic miinst_t nop(input logic [31:0] pc);
    miinst_t m;
    m    = '0;
    m.pc = pc;
    return m;
  endfunction

endpackage

interface miinst_dispatch_queue_if #(
  parameter int DEPTH = 4
);
  import miinst_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  miinst_t            enq_miinst;
  logic               enq_valid;
  logic               enq_ready;
  logic               stall;
  logic               flush;
  miinst_t            deq_miinst_head;
  logic               deq_valid;
  logic [CNT_W-1:0]   count;

  modport master (
    output enq_miinst, enq_valid, stall, flush,
    input  enq_ready, deq_miinst_head, deq_valid, count
  );

  modport slave (
    input  enq_miinst, enq_valid, stall, flush,
    output enq_ready, deq_miinst_head, deq_valid, count
  );

endinterface

// File: rtl/miinst_dispatch_queue.sv
// Micro-instruction FIFO feeding decode; presents the head entry, or nop(last_pc) when empty.
// Ports: i_clk, i_rst (async active-high), io_q (slave modport: enq/stall/flush in; head/deq_valid/enq_ready/count out).
// Optional macro MIQ_BYPASS_EN: empty-queue enqueue is visible at the head in the same cycle (zero latency).
module miinst_dispatch_queue
  import miinst_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  miinst_dispatch_queue_if.slave     io_q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  miinst_t            r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_last_pc;

  logic               w_empty;
  logic               w_enq_ready;
  logic               w_bypass;
  logic               w_bypass_take;
  logic               w_push;
  logic               w_pop;

  assign w_empty     = (r_count == '0);
  // Readiness depends only on occupancy, so a full queue never accepts even if it pops this cycle.
  assign w_enq_ready = (r_count != FULL_CNT);

`ifdef MIQ_BYPASS_EN
  assign w_bypass = w_empty & io_q.enq_valid & ~io_q.flush;
`else
  assign w_bypass = 1'b0;
`endif
  // A bypassed entry consumed directly by decode never touches storage.
  assign w_bypass_take = w_bypass & ~io_q.stall;

  assign w_push = io_q.enq_valid & w_enq_ready & ~io_q.flush & ~w_bypass_take;
  assign w_pop  = ~w_empty & ~io_q.stall & ~io_q.flush;

  assign io_q.enq_ready       = w_enq_ready;
  assign io_q.count           = r_count;
  assign io_q.deq_valid       = ~w_empty | w_bypass;
  assign io_q.deq_miinst_head = !w_empty ? r_mem[r_rd_ptr] :
                                w_bypass ? io_q.enq_miinst : nop(r_last_pc);

  // Storage is deliberately left unreset; validity is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_q.enq_miinst;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_last_pc <= '0;
    end else if (io_q.flush) begin
      // last_pc survives a flush so the nop still carries the last retired pc.
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_last_pc <= r_mem[r_rd_ptr].pc;
      end else if (w_bypass_take) begin
        r_last_pc <= io_q.enq_miinst.pc;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Occupancy must stay within 0..DEPTH.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(w_push && !w_pop && r_count == FULL_CNT))
        else $error("dispatch queue overflow");
      assert (!(w_pop && !w_push && r_count == '0))
        else $error("dispatch queue underflow");
    end
  end

endmodule

// File: tb/tb_miinst_dispatch_queue.sv
// Directed self-checking bench for miinst_dispatch_queue (DEPTH=4), valid with or without MIQ_BYPASS_EN.
// Inputs change 1ns after the rising edge; outputs are sampled 3ns after the edge.
module tb_miinst_dispatch_queue;
  import miinst_pkg::*;

  logic i_clk;
  logic i_rst;
  int   n_chk;
  int   n_fail;

  miinst_dispatch_queue_if #(.DEPTH(4)) q_if ();

  miinst_dispatch_queue #(.DEPTH(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .io_q  (q_if.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic miinst_t mk(input logic [31:0] pc);
    miinst_t m;
    m        = '0;
    m.pc     = pc;
    m.opcode = 8'h10 | {4'h0, pc[3:0]};
    m.rd     = pc[4:0];
    m.rs1    = 5'd1;
    m.rs2    = 5'd2;
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input miinst_t m, input logic st, input logic fl);
    q_if.enq_valid  = v;
    q_if.enq_miinst = m;
    q_if.stall      = st;
    q_if.flush      = fl;
  endtask

  task automatic chk_head(input string tag, input miinst_t exp_head, input logic exp_vld, input int exp_cnt);
    check_eq({tag, "_head"}, 64'(q_if.deq_miinst_head), 64'(exp_head));
    check_eq({tag, "_vld"},  64'(q_if.deq_valid),       64'(exp_vld));
    check_eq({tag, "_cnt"},  64'(q_if.count),           64'(exp_cnt));
  endtask

  miinst_t exp_h2 [5];
  logic    exp_v2 [5];
  int      exp_c2 [5];
  logic    pending;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    i_rst  = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    // Reset state
    chk_head("rst", nop(32'd0), 1'b0, 0);
    check_eq("rst_rdy", 64'(q_if.enq_ready), 64'd1);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // 1: fill to three under stall, then async reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      drive(1'b1, mk(32'd1 + 32'(i)), 1'b1, 1'b0);
    end
    next_cyc();
    drive(1'b0, '0, 1'b1, 1'b0);
    #2;
    check_eq("t1_cnt3", 64'(q_if.count), 64'd3);
    i_rst = 1'b1;
    #1;
    chk_head("t1_rst", nop(32'd0), 1'b0, 0);
    check_eq("t1_rdy", 64'(q_if.enq_ready), 64'd1);
    #1;
    i_rst = 1'b0;

    // 2: A,B,C streamed with no stall
`ifdef MIQ_BYPASS_EN
    exp_h2 = '{mk(32'd10), mk(32'd11), mk(32'd12), nop(32'd12), nop(32'd12)};
    exp_v2 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_c2 = '{0, 0, 0, 0, 0};
`else
    exp_h2 = '{nop(32'd0), mk(32'd10), mk(32'd11), mk(32'd12), nop(32'd12)};
    exp_v2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_c2 = '{0, 1, 1, 1, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      if (i < 3) drive(1'b1, mk(32'd10 + 32'(i)), 1'b0, 1'b0);
      else       drive(1'b0, '0, 1'b0, 1'b0);
      #2;
      chk_head($sformatf("t2_c%0d", i), exp_h2[i], exp_v2[i], exp_c2[i]);
    end

    // 3: five pushes under stall; fifth held until room, then all drain in order
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      drive(1'b1, mk(32'd30 + 32'(i)), 1'b1, 1'b0);
    end
    next_cyc();
    drive(1'b1, mk(32'd34), 1'b1, 1'b0);
    #2;
    chk_head("t3_full", mk(32'd30), 1'b1, 4);
    check_eq("t3_rdy0", 64'(q_if.enq_ready), 64'd0);
    next_cyc();
    #2;
    check_eq("t3_hold_cnt", 64'(q_if.count), 64'd4);
    check_eq("t3_hold_rdy", 64'(q_if.enq_ready), 64'd0);
    pending = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_cyc();
      drive(pending, mk(32'd34), 1'b0, 1'b0);
      #2;
      check_eq($sformatf("t3_pop%0d", k), 64'(q_if.deq_miinst_head), 64'(mk(32'd30 + 32'(k))));
      if (pending && q_if.enq_ready) pending = 1'b0;
    end
    check_eq("t3_accepted", 64'(pending), 64'd0);
    next_cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    chk_head("t3_empty", nop(32'd34), 1'b0, 0);

    // 4: hold two entries, push+pop every cycle for 8 cycles
    next_cyc();
    drive(1'b1, mk(32'd40), 1'b1, 1'b0);
    next_cyc();
    drive(1'b1, mk(32'd41), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      drive(1'b1, mk(32'd42 + 32'(i)), 1'b0, 1'b0);
      #2;
      chk_head($sformatf("t4_c%0d", i), mk(32'd40 + 32'(i)), 1'b1, 2);
    end
    next_cyc();
    drive(1'b1, mk(32'd50), 1'b1, 1'b0);
    #2;
    chk_head("t4_end", mk(32'd48), 1'b1, 2);

    // 5: flush at count 3 with a concurrent enqueue
    next_cyc();
    drive(1'b1, mk(32'd99), 1'b0, 1'b1);
    #2;
    check_eq("t5_pre_cnt", 64'(q_if.count), 64'd3);
    next_cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    chk_head("t5_post", nop(32'd47), 1'b0, 0);
    check_eq("t5_rdy", 64'(q_if.enq_ready), 64'd1);

    // 6: single push into empty queue
    next_cyc();
    drive(1'b1, mk(32'd20), 1'b0, 1'b0);
    #2;
`ifdef MIQ_BYPASS_EN
    chk_head("t6_same", mk(32'd20), 1'b1, 0);
`else
    chk_head("t6_same", nop(32'd47), 1'b0, 0);
`endif
    next_cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
`ifdef MIQ_BYPASS_EN
    chk_head("t6_next", nop(32'd20), 1'b0, 0);
`else
    chk_head("t6_next", mk(32'd20), 1'b1, 1);
`endif
    next_cyc();
    #2;
    chk_head("t6_drain", nop(32'd20), 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
